// File: rtl/alu_exec.sv
// RV32I integer execute unit: single-cycle logic/arith/compare and an iterative
// one-bit-per-cycle shifter, with valid/ready handshakes on input and output.
module alu_exec (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic [4:0]  alu_sel,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic        err,
   output logic        busy
);

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] ALU_LUI  = 5'd10;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

   state_t      state;
   state_t      state_next;
   shift_t      sh_kind;
   shift_t      sh_sel;
   logic [31:0] acc;
   logic [31:0] acc_step;
   logic [4:0]  cnt;
   logic [4:0]  shamt;
   logic [31:0] alu_out;
   logic        alu_illegal;
   logic        is_shift;
   logic        start_shift;
   logic        take;

   assign shamt       = op2[4:0];
   assign start_shift = is_shift && (shamt != 5'd0);
   // A flush on the accept edge suppresses the accept entirely.
   assign take        = in_valid && in_ready && !flush;

   // Single-cycle datapath. A shift by zero passes op1 straight through.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      alu_out     = '0;
      alu_illegal = 1'b0;
      is_shift    = 1'b0;
      sh_sel      = SH_LL;
      case (alu_sel)
         ALU_ADD:  alu_out = op1 + op2;
         ALU_SUB:  alu_out = op1 - op2;
         ALU_SLT:  alu_out = {31'd0, $signed(op1) < $signed(op2)};
         ALU_SLTU: alu_out = {31'd0, op1 < op2};
         ALU_XOR:  alu_out = op1 ^ op2;
         ALU_OR:   alu_out = op1 | op2;
         ALU_AND:  alu_out = op1 & op2;
         ALU_LUI:  alu_out = op1 << 12;
         ALU_SLL: begin
            alu_out  = op1;
            is_shift = 1'b1;
            sh_sel   = SH_LL;
         end
         ALU_SRL: begin
            alu_out  = op1;
            is_shift = 1'b1;
            sh_sel   = SH_RL;
         end
         ALU_SRA: begin
            alu_out  = op1;
            is_shift = 1'b1;
            sh_sel   = SH_RA;
         end
         default:  alu_illegal = 1'b1;
      endcase
   end

   always_comb begin
      acc_step = acc;
      case (sh_kind)
         SH_LL:   acc_step = {acc[30:0], 1'b0};
         SH_RL:   acc_step = {1'b0, acc[31:1]};
         SH_RA:   acc_step = {acc[31], acc[31:1]};
         default: acc_step = acc;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (take) state_next = start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
               if (cnt == 5'd1) state_next = DONE;
            end
            DONE: begin
               if (take)           state_next = start_shift ? SHIFT : DONE;
               else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Output logic; in_ready looks through to out_ready so DONE can re-accept.
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Datapath registers. result/zero/err only move when an op completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         sh_kind <= SH_LL;
         result  <= '0;
         zero    <= 1'b1;
         err     <= 1'b0;
      end else if (!flush) begin
         if (take) begin
            if (start_shift) begin
               acc     <= op1;
               cnt     <= shamt;
               sh_kind <= sh_sel;
            end else begin
               result <= alu_out;
               zero   <= (alu_out == 32'd0);
               err    <= alu_illegal;
            end
         end else if (state == SHIFT) begin
            acc <= acc_step;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
               result <= acc_step;
               zero   <= (acc_step == 32'd0);
               err    <= 1'b0;
            end
         end
      end
   end

endmodule
